// File: rtl/prio_level_ctrl.sv
// Interrupt entry/exit sequencer. Owns the current execution priority level,
// which doubles as the register-bank select, and keeps a LIFO of interrupted
// levels so that returns restore the level that was preempted.
//
// Handshake: irq_valid/irq_prio are held by the arbiter until irq_ack pulses;
// irq_ack with ack_prio marks the single cycle in which that priority was taken.
// A request that is not taken (stall, ENTER, or priority not above level) is
// simply left pending. ret_req is a one-cycle strobe from the core and is not
// acknowledged; a return seen while stalled or in ENTER is dropped.
module prio_level_ctrl #(
    parameter int PrioNum   = 8,
    parameter int PrioWidth = $clog2(PrioNum)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 irq_valid,
    input  logic [PrioWidth-1:0] irq_prio,
    input  logic                 ret_req,
    input  logic                 stall,
    output logic [PrioWidth-1:0] level,
    output logic                 ra_write_en,
    output logic                 irq_ack,
    output logic [PrioWidth-1:0] ack_prio,
    output logic [PrioWidth-1:0] depth,
    output logic                 err_underflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        ENTER = 1'b1
    } stateT;

    stateT state;

    // Interrupted levels, bottom of stack at index 0. Levels on the stack are
    // strictly increasing, so PrioNum-1 entries always suffice.
    logic [PrioWidth-1:0] levelStack [0:PrioNum-2];

    logic [PrioWidth-1:0] popIdx;
    logic [PrioWidth-1:0] popLevel;
    logic                 canDecide;
    logic                 hasStack;
    logic                 doReturn;
    logic                 doTail;
    logic                 doPop;
    logic                 doUnder;
    logic                 doPush;

    // Decode the IDLE decision for this cycle from current state and inputs.
    always_comb begin
        popIdx    = depth - PrioWidth'(1);
        popLevel  = levelStack[popIdx];
        canDecide = (state == IDLE) && !stall;
        hasStack  = (depth != '0);
        doReturn  = canDecide && ret_req && hasStack;
        // Tail-chain: the pop and the push cancel, so the stack top stays put.
        doTail    = doReturn && irq_valid && (irq_prio > popLevel);
        doPop     = doReturn && !doTail;
        doUnder   = canDecide && ret_req && !hasStack;
        // An underflowing return does not block a coincident preempt.
        doPush    = canDecide && (!ret_req || !hasStack) && irq_valid && (irq_prio > level);
    end

    // Level stack storage; contents need no reset because depth gates reads.
    always_ff @(posedge clk) begin
        if (doPush) begin
            levelStack[depth] <= level;
        end
    end

    // Sequencer: level/depth bookkeeping and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            level         <= '0;
            depth         <= '0;
            ra_write_en   <= 1'b0;
            irq_ack       <= 1'b0;
            ack_prio      <= '0;
            err_underflow <= 1'b0;
        end else begin
            ra_write_en   <= 1'b0;
            irq_ack       <= 1'b0;
            err_underflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (doUnder) begin
                        err_underflow <= 1'b1;
                    end
                    if (doPush) begin
                        level       <= irq_prio;
                        depth       <= depth + PrioWidth'(1);
                        irq_ack     <= 1'b1;
                        ack_prio    <= irq_prio;
                        ra_write_en <= 1'b1;
                        state       <= ENTER;
                    end else if (doTail) begin
                        level       <= irq_prio;
                        irq_ack     <= 1'b1;
                        ack_prio    <= irq_prio;
                        ra_write_en <= 1'b1;
                        state       <= ENTER;
                    end else if (doPop) begin
                        level <= popLevel;
                        depth <= depth - PrioWidth'(1);
                    end
                end
                // ENTER lasts one cycle with the new bank selected; the
                // ra_write_en raised on entry drops as we leave.
                ENTER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A push at full depth would mean the stacked levels were not increasing.
    assert property (@(posedge clk) disable iff (reset)
        !(doPush && (depth == PrioWidth'(PrioNum - 1))));

endmodule

// File: tb/tb_prio_level_ctrl.sv
// Directed bench for prio_level_ctrl: entry, nesting, tail-chain, underflow,
// stall, back-to-back entries, reset during ENTER and full stack depth.
module tb_prio_level_ctrl;

    localparam int PN = 8;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          irq_valid;
    logic [PW-1:0] irq_prio;
    logic          ret_req;
    logic          stall;
    logic [PW-1:0] level;
    logic          ra_write_en;
    logic          irq_ack;
    logic [PW-1:0] ack_prio;
    logic [PW-1:0] depth;
    logic          err_underflow;

    int total = 0;
    int bad   = 0;
    logic [11:0] e;

    prio_level_ctrl #(.PrioNum(PN), .PrioWidth(PW)) dut (
        .clk           (clk),
        .reset         (reset),
        .irq_valid     (irq_valid),
        .irq_prio      (irq_prio),
        .ret_req       (ret_req),
        .stall         (stall),
        .level         (level),
        .ra_write_en   (ra_write_en),
        .irq_ack       (irq_ack),
        .ack_prio      (ack_prio),
        .depth         (depth),
        .err_underflow (err_underflow)
    );

    // Clock and a hard time limit.
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    // Observed outputs packed as {level, depth, ra, ack, ack_prio, err};
    // ack_prio only matters while irq_ack is high.
    function automatic logic [11:0] snap();
        return {level, depth, ra_write_en, irq_ack, (irq_ack ? ack_prio : 3'd0), err_underflow};
    endfunction

    function automatic logic [11:0] pk(input logic [2:0] l, input logic [2:0] d, input logic ra,
                                       input logic ak, input logic [2:0] ap, input logic er);
        return {l, d, ra, ak, ap, er};
    endfunction

    task automatic drive(input logic iv, input logic [PW-1:0] ip, input logic rr, input logic st);
        irq_valid = iv;
        irq_prio  = ip;
        ret_req   = rr;
        stall     = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        step();
        step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL reset_state got=%b want=%b", snap(), e); end
        total++; if (ack_prio !== 3'd0) begin bad++; $display("FAIL reset_ack_prio got=%0d want=0", ack_prio); end
        reset = 1'b0;
        step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL post_reset_idle got=%b want=%b", snap(), e); end
    endtask

    task automatic test_entry();
        drive(1'b1, 3'd3, 1'b0, 1'b0); step();
        e = pk(3,1,1,1,3,0); total++; if (snap() !== e) begin bad++; $display("FAIL entry_3 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        e = pk(3,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL entry_3_settle got=%b want=%b", snap(), e); end
    endtask

    task automatic test_nested();
        drive(1'b1, 3'd5, 1'b0, 1'b0); step();
        e = pk(5,2,1,1,5,0); total++; if (snap() !== e) begin bad++; $display("FAIL nest_enter_5 got=%b want=%b", snap(), e); end
        drive(1'b1, 3'd2, 1'b0, 1'b0); step();
        e = pk(5,2,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL nest_leave_enter got=%b want=%b", snap(), e); end
        step();
        e = pk(5,2,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL nest_lower_ignored got=%b want=%b", snap(), e); end
        drive(1'b1, 3'd5, 1'b0, 1'b0); step();
        e = pk(5,2,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL nest_equal_ignored got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(3,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL nest_ret_to_3 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        e = pk(3,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL nest_hold_3 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL nest_ret_to_0 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
    endtask

    task automatic test_tail_chain();
        drive(1'b1, 3'd4, 1'b0, 1'b0); step();
        e = pk(4,1,1,1,4,0); total++; if (snap() !== e) begin bad++; $display("FAIL tc_enter_4 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd2, 1'b1, 1'b0); step();
        e = pk(2,1,1,1,2,0); total++; if (snap() !== e) begin bad++; $display("FAIL tc_chain_2 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        e = pk(2,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL tc_chain_settle got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL tc_ret_0 got=%b want=%b", snap(), e); end
        // Stack [0,3], level 5: a lower or equal pending irq leads to a plain return.
        drive(1'b1, 3'd3, 1'b0, 1'b0); step();
        drive(1'b1, 3'd5, 1'b0, 1'b0); step();
        drive(1'b1, 3'd5, 1'b0, 1'b0); step();
        e = pk(5,2,1,1,5,0); total++; if (snap() !== e) begin bad++; $display("FAIL tc_build_5 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd2, 1'b1, 1'b0); step();
        e = pk(3,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL tc_plain_lower got=%b want=%b", snap(), e); end
        drive(1'b1, 3'd5, 1'b0, 1'b0); step();
        e = pk(5,2,1,1,5,0); total++; if (snap() !== e) begin bad++; $display("FAIL tc_reenter_5 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        drive(1'b1, 3'd3, 1'b1, 1'b0); step();
        e = pk(3,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL tc_plain_equal got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL tc_final_ret got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
    endtask

    task automatic test_underflow();
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(0,0,0,0,0,1); total++; if (snap() !== e) begin bad++; $display("FAIL uf_strobe got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL uf_clear got=%b want=%b", snap(), e); end
        drive(1'b1, 3'd1, 1'b1, 1'b0); step();
        e = pk(1,1,1,1,1,1); total++; if (snap() !== e) begin bad++; $display("FAIL uf_with_irq got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL uf_ret_0 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd6, 1'b0, 1'b1); step();
            e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL stall_hold_%0d got=%b want=%b", i, snap(), e); end
        end
        drive(1'b1, 3'd6, 1'b0, 1'b0); step();
        e = pk(6,1,1,1,6,0); total++; if (snap() !== e) begin bad++; $display("FAIL stall_release got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b1); step();
        e = pk(6,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL stall_in_enter got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b1, 1'b1); step();
        e = pk(6,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL stall_ret_ignored got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL stall_ret_0 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd2, 1'b0, 1'b0); step();
        e = pk(2,1,1,1,2,0); total++; if (snap() !== e) begin bad++; $display("FAIL b2b_first got=%b want=%b", snap(), e); end
        drive(1'b1, 3'd4, 1'b1, 1'b0); step();
        e = pk(2,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL b2b_enter_ignores got=%b want=%b", snap(), e); end
        drive(1'b1, 3'd4, 1'b0, 1'b0); step();
        e = pk(4,2,1,1,4,0); total++; if (snap() !== e) begin bad++; $display("FAIL b2b_second got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(2,1,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL b2b_ret_2 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL b2b_ret_0 got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
    endtask

    task automatic test_reset_in_enter();
        drive(1'b1, 3'd3, 1'b0, 1'b0); step();
        e = pk(3,1,1,1,3,0); total++; if (snap() !== e) begin bad++; $display("FAIL rst_enter_pre got=%b want=%b", snap(), e); end
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL rst_enter_post got=%b want=%b", snap(), e); end
        reset = 1'b0; step();
        drive(1'b1, 3'd1, 1'b0, 1'b0); step();
        e = pk(1,1,1,1,1,0); total++; if (snap() !== e) begin bad++; $display("FAIL rst_enter_again got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        drive(1'b0, 3'd0, 1'b1, 1'b0); step();
        e = pk(0,0,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL rst_enter_ret got=%b want=%b", snap(), e); end
        drive(1'b0, 3'd0, 1'b0, 1'b0); step();
    endtask

    task automatic test_full_depth();
        for (int p = 1; p < PN; p++) begin
            drive(1'b1, 3'(p), 1'b0, 1'b0); step();
            e = pk(3'(p),3'(p),1,1,3'(p),0); total++; if (snap() !== e) begin bad++; $display("FAIL full_push_%0d got=%b want=%b", p, snap(), e); end
            drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        end
        drive(1'b1, 3'd7, 1'b0, 1'b0); step();
        e = pk(7,7,0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL full_top_equal got=%b want=%b", snap(), e); end
        for (int i = PN - 2; i >= 0; i--) begin
            drive(1'b0, 3'd0, 1'b1, 1'b0); step();
            e = pk(3'(i),3'(i),0,0,0,0); total++; if (snap() !== e) begin bad++; $display("FAIL full_pop_%0d got=%b want=%b", i, snap(), e); end
            drive(1'b0, 3'd0, 1'b0, 1'b0); step();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        test_reset();
        test_entry();
        test_nested();
        test_tail_chain();
        test_underflow();
        test_stall();
        test_back_to_back();
        test_reset_in_enter();
        test_full_depth();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
